// File: rtl/alu_bit_serial_seq_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: op codes, FSM states
// and the single-bit logic function used by the datapath slice.
package alu_seq_pkg;

    // Op codes {S1,S0}
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NOTX = 2'b11;

    // Sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // One result bit from one X bit and one Y bit; Y is don't-care for NOT X
    function automatic logic alu_bit(input logic x, input logic y, input logic [1:0] op);
        logic r;
        case (op)
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_NOTX: r = ~x;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_bit_serial_seq_alu_1bit.sv
// Combinational one-bit ALU slice; the sequencer feeds it one operand bit
// pair per clock.
module ALU_1bit
    import alu_seq_pkg::*;
(
    input  logic       i_x,
    input  logic       i_y,
    input  logic [1:0] i_s,
    output logic       o_r
);

    // Pure function of the current bit pair and the frozen op code
    always_comb begin
        o_r = alu_bit(i_x, i_y, i_s);
    end

endmodule

// File: rtl/alu_bit_serial_seq.sv
// Bit-serial operand sequencer: accepts an X/Y/op triple, streams the
// operands LSB-first through a single ALU_1bit, reassembles the result and
// hands it downstream. One operation in flight at a time.
module alu_bit_serial_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_x,
    input  logic [WIDTH-1:0] i_in_y,
    input  logic [1:0]       i_in_op,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_r,
    output logic             o_busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_x_sr;
    logic [WIDTH-1:0] r_y_sr;
    logic [WIDTH-1:0] r_r_sr;
    logic [WIDTH-1:0] r_out_r;
    logic [1:0]       r_op_q;
    logic [CNT_W-1:0] r_cnt;

    logic             w_alu_r;
    logic [WIDTH-1:0] w_r_next;
    logic             w_last;

    ALU_1bit u_alu (
        .i_x (r_x_sr[0]),
        .i_y (r_y_sr[0]),
        .i_s (r_op_q),
        .o_r (w_alu_r)
    );

    // New result bit enters at the MSB so the LSB-first stream lands in place
    assign w_r_next = {w_alu_r, r_r_sr[WIDTH-1:1]};
    assign w_last   = (r_cnt == CNT_LAST);

    // FSM transitions for both handshakes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (i_in_valid)  r_state <= ST_SHIFT;
                ST_SHIFT: if (w_last)      r_state <= ST_DONE;
                ST_DONE:  if (i_out_ready) r_state <= ST_IDLE;
                default:                   r_state <= ST_IDLE;
            endcase
        end
    end

    // Operand capture and per-bit shifting; op is frozen at acceptance
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x_sr <= '0;
            r_y_sr <= '0;
            r_r_sr <= '0;
            r_op_q <= OP_AND;
            r_cnt  <= '0;
        end else if (r_state == ST_IDLE) begin
            if (i_in_valid) begin
                r_x_sr <= i_in_x;
                r_y_sr <= i_in_y;
                r_op_q <= i_in_op;
                r_r_sr <= '0;
                r_cnt  <= '0;
            end
        end else if (r_state == ST_SHIFT) begin
            r_r_sr <= w_r_next;
            r_x_sr <= r_x_sr >> 1;
            r_y_sr <= r_y_sr >> 1;
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    // Result word register: loaded with the completed word on entry to DONE,
    // held at all other times so the consumer sees a stable value
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_r <= '0;
        end else if (r_state == ST_SHIFT && w_last) begin
            r_out_r <= w_r_next;
        end
    end

    assign o_in_ready  = (r_state == ST_IDLE);
    assign o_out_valid = (r_state == ST_DONE);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_out_r     = r_out_r;

endmodule

// File: tb/tb_alu_bit_serial_seq.sv
// Scoreboard bench for the bit-serial ALU sequencer: the driver pushes the
// word-level expected result and acceptance edge, a monitor checks latency
// on out_valid rise and data on every output handshake.
module tb_alu_bit_serial_seq;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] r;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_x = '0;
    logic [W-1:0] in_y = '0;
    logic [1:0]   in_op = 2'b00;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_r;
    logic         busy;

    logic dir_rdy = 1'b1;
    logic rnd_rdy = 1'b1;
    logic rand_bp = 1'b0;
    assign out_ready = rand_bp ? rnd_rdy : dir_rdy;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t q[$];

    alu_bit_serial_seq #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_x      (in_x),
        .i_in_y      (in_y),
        .i_in_op     (in_op),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_r     (out_r),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);

    // Word-level reference: whole-operand logic ops
    function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [1:0] op);
        case (op)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~x;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation; returns the acceptance edge number (-1 on timeout)
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] op,
                        output int acc);
        int n;
        exp_t e;
        @(negedge clk);
        in_x = x; in_y = y; in_op = op; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL send_timeout: in_ready stayed %0b, expected 1", in_ready);
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        e.r = model(x, y, op);
        e.acc = acc;
        q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", q.size());
            q.delete();
        end
    endtask

    // Monitor: latency on out_valid rise, data on each handshake
    initial begin
        logic prev_v = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (out_valid && !prev_v) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_valid: out_r=%0h with empty scoreboard", out_r);
                end else begin
                    chk("latency_edge", 32'(cyc), 32'(q[0].acc + W));
                end
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_result: got %0h, expected none", out_r);
                end else begin
                    chk("result", 32'(out_r), 32'(q[0].r));
                    void'(q.pop_front());
                end
            end
            prev_v = out_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1;
        logic [1:0] op;
        rst_n = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_r", 32'(out_r), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic ops
        send(8'hA5, 8'h3C, 2'b00, a0);
        chk("busy_in_shift", 32'(busy), 32'd1);
        drain();
        send(8'hA5, 8'h3C, 2'b01, a0);
        send(8'hA5, 8'h3C, 2'b10, a0);
        send(8'hA5, 8'hFF, 2'b11, a0);
        send(8'hA5, 8'h00, 2'b11, a0);
        drain();

        // Backpressure: stall in DONE, new request must not be taken
        dir_rdy = 1'b0;
        send(8'hA5, 8'h3C, 2'b00, a0);
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        chk("bp_valid", 32'(out_valid), 32'd1);
        in_x = 8'hFF; in_y = 8'h00; in_op = 2'b01; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_r", 32'(out_r), 32'h24);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_valid_hold", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        dir_rdy = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        drain();

        // Reset mid-shift
        send(8'hF0, 8'hFF, 2'b00, a0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_r", 32'(out_r), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h0F, 8'hF0, 2'b01, a0);
        drain();

        // Op changes after acceptance are ignored
        send(8'hAA, 8'hCC, 2'b00, a0);
        in_op = 2'b10;
        drain();

        // Back-to-back initiation interval
        send(8'h12, 8'h34, 2'b10, a0);
        send(8'h56, 8'h78, 2'b01, a1);
        chk("init_interval", 32'(a1 - a0), 32'(W + 2));
        drain();

        // Random ops with random consumer backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            send(W'($urandom), W'($urandom), op, a0);
        end
        drain();
        rand_bp = 1'b0;
        repeat (3) @(negedge clk);
        chk("end_idle", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
